// File: rtl/mandel_iter_update_if.sv
// mandel_iter_update_if: job handshake plus multiplier feed/return bus of the iteration stage
interface mandel_iter_update_if #(
   parameter int W  = 32,
   parameter int IW = 16
);
   logic          start, busy, done, escaped;
   logic [W-1:0]  c_re, c_im, a_out, b_out, a0_out, b0_out;
   logic [W-1:0]  aa_in, bb_in, ab_in, a0_in, b0_in;
   logic [IW-1:0] max_iter, iter_count;
   modport master (
      output start, c_re, c_im, max_iter, aa_in, bb_in, ab_in, a0_in, b0_in,
      input  busy, done, escaped, iter_count, a_out, b_out, a0_out, b0_out
   );
   modport slave (
      input  start, c_re, c_im, max_iter, aa_in, bb_in, ab_in, a0_in, b0_in,
      output busy, done, escaped, iter_count, a_out, b_out, a0_out, b0_out
   );
endinterface

// File: rtl/mandel_iter_update.sv
// mandel_iter_update: escape test and z <- z^2 + c update closing the fractal iteration loop
module mandel_iter_update #(
   parameter int W       = 32,
   parameter int FRAC    = 28,
   parameter int IW      = 16,
   parameter int MUL_LAT = 1
) (
   input logic aclk,
   input logic ld,
   mandel_iter_update_if.slave m
);
   localparam int WW = MUL_LAT > 1 ? $clog2(MUL_LAT + 1) : 1;
   localparam logic signed [W:0] FOUR = (W+1)'(4) << FRAC;
   // state bit 0 is busy, bit 1 is done, so both flags come straight from flops
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
   state_t state, state_n;
   logic [WW-1:0] wt, wt_n;
   logic [W-1:0] a, a_n, b, b_n, a0, a0_n, b0, b0_n;
   logic [IW-1:0] it, it_n, mi, mi_n, it_inc;
   logic esc, esc_n, over;
   logic signed [W:0] mag;
   logic [W-1:0] nxt_a, nxt_b;
   // a negative square can only come from multiplier overflow, so it escapes too
   assign mag = $signed({m.aa_in[W-1], m.aa_in}) + $signed({m.bb_in[W-1], m.bb_in});
   assign over = mag > FOUR || m.aa_in[W-1] || m.bb_in[W-1];
   assign nxt_a = m.aa_in - m.bb_in + m.a0_in;
   assign nxt_b = {m.ab_in[W-2:0], 1'b0} + m.b0_in;
   assign it_inc = it + 1'b1;
   always_ff @(posedge aclk) begin
      if (ld) begin
         state <= IDLE;
         wt    <= '0;
         a     <= '0;
         b     <= '0;
         a0    <= '0;
         b0    <= '0;
         it    <= '0;
         mi    <= '0;
         esc   <= 1'b0;
      end else begin
         state <= state_n;
         wt    <= wt_n;
         a     <= a_n;
         b     <= b_n;
         a0    <= a0_n;
         b0    <= b0_n;
         it    <= it_n;
         mi    <= mi_n;
         esc   <= esc_n;
      end
   end
   always_comb begin
      state_n = state;
      wt_n    = wt;
      a_n     = a;
      b_n     = b;
      a0_n    = a0;
      b0_n    = b0;
      it_n    = it;
      mi_n    = mi;
      esc_n   = esc;
      if (state != RUN && m.start) begin
         a_n     = '0;
         b_n     = '0;
         a0_n    = m.c_re;
         b0_n    = m.c_im;
         it_n    = '0;
         mi_n    = m.max_iter;
         esc_n   = 1'b0;
         wt_n    = '0;
         state_n = m.max_iter == '0 ? DONE : RUN;
      end else if (state == RUN) begin
         wt_n = wt + 1'b1;
         if (wt == WW'(MUL_LAT)) begin
            if (over) begin
               esc_n   = 1'b1;
               state_n = DONE;
            end else begin
               a_n     = nxt_a;
               b_n     = nxt_b;
               it_n    = it_inc;
               wt_n    = '0;
               state_n = it_inc == mi ? DONE : RUN;
            end
         end
      end
   end
   assign m.a_out      = a;
   assign m.b_out      = b;
   assign m.a0_out     = a0;
   assign m.b0_out     = b0;
   assign m.busy       = state[0];
   assign m.done       = state[1];
   assign m.escaped    = esc;
   assign m.iter_count = it;
endmodule

// File: tb/tb_mandel_iter_update.sv
// tb_mandel_iter_update: directed jobs against a saturating multiplier model and a software reference
module tb_mandel_iter_update;
   typedef struct {
      logic        esc;
      logic [15:0] cnt;
      logic [31:0] a, b, a0, b0;
      int          cyc;
   } exp_t;
   logic aclk = 0, ld = 1;
   int   cyc = 0, s_cyc = 0, errors = 0, checks = 0;
   exp_t sb[$];
   mandel_iter_update_if #(.W(32), .IW(16)) m();
   mandel_iter_update #(.W(32), .FRAC(28), .IW(16), .MUL_LAT(1)) dut (.aclk(aclk), .ld(ld), .m(m));
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;
   // Q4.28 multiply with saturation, one register stage, c carried alongside
   function automatic logic [31:0] mul(input logic [31:0] x, input logic [31:0] y);
      longint p;
      p = (longint'($signed(x)) * longint'($signed(y))) >>> 28;
      if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
      if (p < -64'sh8000_0000) return 32'h8000_0000;
      return p[31:0];
   endfunction
   always @(posedge aclk) begin
      m.aa_in <= mul(m.a_out, m.a_out);
      m.bb_in <= mul(m.b_out, m.b_out);
      m.ab_in <= mul(m.a_out, m.b_out);
      m.a0_in <= m.a0_out;
      m.b0_in <= m.b0_out;
   end
   function automatic exp_t model(input logic [31:0] cr, input logic [31:0] ci, input logic [15:0] mx);
      exp_t e;
      logic [31:0] aa, bb, ab;
      longint mag;
      int n = 0;
      e.a = 0; e.b = 0; e.esc = 0; e.a0 = cr; e.b0 = ci;
      while (n < int'(mx)) begin
         aa = mul(e.a, e.a); bb = mul(e.b, e.b); ab = mul(e.a, e.b);
         mag = longint'($signed(aa)) + longint'($signed(bb));
         if (mag > 64'sh4000_0000 || $signed(aa) < 0 || $signed(bb) < 0) begin
            e.esc = 1;
            break;
         end
         e.a = aa - bb + cr;
         e.b = ab * 2 + ci;
         n++;
      end
      e.cnt = 16'(n);
      e.cyc = mx == 0 ? 0 : e.esc ? 2 * (n + 1) : 2 * n;
      return e;
   endfunction
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_zero(input string p);
      check({p, "_a_out"}, m.a_out, 0);
      check({p, "_b_out"}, m.b_out, 0);
      check({p, "_a0_out"}, m.a0_out, 0);
      check({p, "_b0_out"}, m.b0_out, 0);
      check({p, "_busy"}, m.busy, 0);
      check({p, "_done"}, m.done, 0);
      check({p, "_escaped"}, m.escaped, 0);
      check({p, "_iter"}, m.iter_count, 0);
   endtask
   task automatic launch(input logic [31:0] cr, input logic [31:0] ci, input logic [15:0] mx, input bit push);
      @(negedge aclk);
      m.start = 1; m.c_re = cr; m.c_im = ci; m.max_iter = mx;
      @(posedge aclk); #1;
      s_cyc = cyc;
      m.start = 0;
      if (push) sb.push_back(model(cr, ci, mx));
      check("start_busy", m.busy, mx != 0);
      check("start_done", m.done, mx == 0);
   endtask
   task automatic finish_job(input string t);
      exp_t e;
      int n = 0;
      logic busy_ok = 1;
      while (m.done !== 1'b1 && n < 1000) begin
         if (m.busy !== 1'b1) busy_ok = 0;
         @(posedge aclk); #1;
         n++;
      end
      check({t, "_done"}, m.done, 1);
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", t);
         return;
      end
      e = sb.pop_front();
      check({t, "_cycles"}, cyc - s_cyc, e.cyc);
      check({t, "_escaped"}, m.escaped, e.esc);
      check({t, "_iter"}, m.iter_count, e.cnt);
      check({t, "_a_out"}, m.a_out, e.a);
      check({t, "_b_out"}, m.b_out, e.b);
      check({t, "_a0_out"}, m.a0_out, e.a0);
      check({t, "_b0_out"}, m.b0_out, e.b0);
      check({t, "_busy_low"}, m.busy, 0);
      check({t, "_busy_run"}, busy_ok, 1);
   endtask
   initial begin
      m.start = 0; m.c_re = 0; m.c_im = 0; m.max_iter = 0;
      repeat (3) @(posedge aclk);
      #1 check_zero("reset");
      ld = 0;
      launch(32'h0, 32'h0, 16'd10, 1);
      finish_job("origin");
      launch(32'h2000_0000, 32'h0, 16'd50, 1);
      finish_job("two");
      launch(32'hE000_0000, 32'h0, 16'd5, 1);
      finish_job("minus_two");
      launch(32'h1234_5678, 32'h0FED_CBA9, 16'd0, 1);
      finish_job("max_zero");
      // abort a running job, then confirm a clean restart
      launch(32'h0, 32'h0, 16'd10, 0);
      repeat (4) @(posedge aclk);
      #1 ld = 1;
      @(posedge aclk);
      #1 check_zero("abort");
      ld = 0;
      repeat (25) @(posedge aclk);
      #1 check("abort_no_done", m.done, 0);
      launch(32'h2000_0000, 32'h0, 16'd50, 1);
      finish_job("after_abort");
      launch(32'hF400_0000, 32'h0199_999A, 16'd40, 1);
      finish_job("misc_a");
      launch(32'h0400_0000, 32'h0800_0000, 16'd30, 1);
      finish_job("misc_b");
      // orbit of i, with a stray start mid-run and start held into DONE
      launch(32'h0, 32'h1000_0000, 16'd100, 1);
      repeat (10) @(posedge aclk);
      @(negedge aclk);
      m.start = 1; m.c_re = 32'h2000_0000; m.c_im = 32'h0300_0000; m.max_iter = 16'd3;
      @(negedge aclk);
      m.start = 0;
      repeat (170) @(posedge aclk);
      #1;
      m.start = 1; m.c_re = 32'h2000_0000; m.c_im = 32'h0; m.max_iter = 16'd5;
      finish_job("orbit_i");
      @(posedge aclk); #1;
      s_cyc = cyc;
      sb.push_back(model(32'h2000_0000, 32'h0, 16'd5));
      check("held_done_clear", m.done, 0);
      check("held_busy", m.busy, 1);
      m.start = 0;
      finish_job("held_restart");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
